// File: rtl/shift_pipe_unit.sv
// Pipelined logarithmic shifter for the EX stage: SLL/SRL/SRA/ROTR/ROTL.
// SHAMT_W shift levels are spread over PIPE register stages. A valid/ready
// handshake provides backpressure, and flush discards every op in flight.
// Each result carries its writeback tag.
module shift_pipe_unit #(
  parameter int WIDTH = 32,
  parameter int PIPE = 2,
  parameter int TAG_W = 5,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err
);

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_ROTR = 3'b011;
  localparam logic [2:0] OP_ROTL = 3'b100;

  // Stage registers. The last stage is also the output slot.
  logic [PIPE-1:0]    st_valid;
  logic [PIPE-1:0]    st_sign;
  logic [PIPE-1:0]    st_err;
  logic [WIDTH-1:0]   st_data  [PIPE];
  logic [2:0]         st_op    [PIPE];
  logic [SHAMT_W-1:0] st_shamt [PIPE];
  logic [TAG_W-1:0]   st_tag   [PIPE];

  // Next-state values, one entry per stage.
  logic [PIPE-1:0]    nx_sign;
  logic [PIPE-1:0]    nx_err;
  logic [WIDTH-1:0]   nx_data  [PIPE];
  logic [2:0]         nx_op    [PIPE];
  logic [SHAMT_W-1:0] nx_shamt [PIPE];
  logic [TAG_W-1:0]   nx_tag   [PIPE];

  // Working values while the shift levels are applied in order.
  logic [WIDTH-1:0]   cur_data;
  logic [2:0]         cur_op;
  logic [SHAMT_W-1:0] cur_shamt;
  logic [TAG_W-1:0]   cur_tag;
  logic               cur_sign;
  logic               cur_err;

  logic stall;

  // One shift level. It moves d by 2^k according to op. SRA fills from the
  // sign bit that was captured when the op was accepted.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [2:0] op,
                                                   input logic sgn,
                                                   input int k);
    int n;
    n = 1 << k;
    case (op)
      OP_SLL:  return d << n;
      OP_SRL:  return d >> n;
      OP_SRA:  return (d >> n) | (sgn ? ~({WIDTH{1'b1}} >> n) : '0);
      OP_ROTR: return (d >> n) | (d << (WIDTH - n));
      OP_ROTL: return (d << n) | (d >> (WIDTH - n));
      default: return d;
    endcase
  endfunction

  assign stall     = st_valid[PIPE-1] & ~out_ready;
  assign in_ready  = rst & ~stall & ~flush;
  assign out_valid = st_valid[PIPE-1];
  assign out_data  = st_data[PIPE-1];
  assign out_tag   = st_tag[PIPE-1];
  assign out_err   = st_err[PIPE-1];

  // Datapath: each stage takes its predecessor and applies the levels it owns.
  // An illegal op skips every level, so its operand passes through unchanged.
  always_comb begin
    cur_data  = in_data;
    cur_op    = in_op;
    cur_shamt = in_shamt;
    cur_tag   = in_tag;
    cur_sign  = in_data[WIDTH-1];
    cur_err   = (in_op > OP_ROTL);
    nx_sign   = '0;
    nx_err    = '0;
    for (int s = 0; s < PIPE; s++) begin
      if (s > 0) begin
        cur_data  = st_data[s-1];
        cur_op    = st_op[s-1];
        cur_shamt = st_shamt[s-1];
        cur_tag   = st_tag[s-1];
        cur_sign  = st_sign[s-1];
        cur_err   = st_err[s-1];
      end
      for (int k = 0; k < SHAMT_W; k++) begin
        if (((k * PIPE) / SHAMT_W) == s && cur_shamt[k] && !cur_err) begin
          cur_data = shift_level(cur_data, cur_op, cur_sign, k);
        end
      end
      nx_data[s]  = cur_data;
      nx_op[s]    = cur_op;
      nx_shamt[s] = cur_shamt;
      nx_tag[s]   = cur_tag;
      nx_sign[s]  = cur_sign;
      nx_err[s]   = cur_err;
    end
  end

  // Stage registers: reset clears everything, flush clears only the valids,
  // a stall freezes all stages, and otherwise the pipe advances one step.
  // Bubbles advance too; they are not squeezed out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_valid <= '0;
      st_sign  <= '0;
      st_err   <= '0;
      for (int s = 0; s < PIPE; s++) begin
        st_data[s]  <= '0;
        st_op[s]    <= '0;
        st_shamt[s] <= '0;
        st_tag[s]   <= '0;
      end
    end else if (flush) begin
      st_valid <= '0;
    end else if (!stall) begin
      st_valid[0] <= in_valid;
      for (int s = 1; s < PIPE; s++) begin
        st_valid[s] <= st_valid[s-1];
      end
      st_sign <= nx_sign;
      st_err  <= nx_err;
      for (int s = 0; s < PIPE; s++) begin
        st_data[s]  <= nx_data[s];
        st_op[s]    <= nx_op[s];
        st_shamt[s] <= nx_shamt[s];
        st_tag[s]   <= nx_tag[s];
      end
    end
  end

endmodule
